// File: rtl/reset_request_gen.sv
// Push-button reset request source: synchronises and debounces key_n, then classifies
// each accepted press as short (one-cycle soft_reset) or long (stretched hard_reset level).
module reset_request_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 100_000_000,
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter int unsigned CNT_W           = 28
) (
  input  logic clock,
  input  logic reset_in,
  input  logic key_n,
  output logic key_level,
  output logic soft_reset,
  output logic hard_reset,
  output logic busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PRESS_DB = 3'd1;
  localparam logic [2:0] S_HELD     = 3'd2;
  localparam logic [2:0] S_REL_DB   = 3'd3;
  localparam logic [2:0] S_LONG     = 3'd4;
  localparam logic [2:0] S_LREL_DB  = 3'd5;
  localparam logic [2:0] S_STRETCH  = 3'd6;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       sync_ff;
  logic [2:0]       state;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] hd_cnt;
  logic [CNT_W-1:0] db_inc;
  logic [CNT_W-1:0] hd_inc;
  logic             key_s;
  logic             db_done;

  assign key_s  = ~sync_ff[1];
  assign db_inc = (db_cnt == CNT_MAX) ? db_cnt : db_cnt + CNT_ONE;
  assign hd_inc = (hd_cnt == CNT_MAX) ? hd_cnt : hd_cnt + CNT_ONE;
  // The edge that leaves IDLE already saw one stable sample, so the window closes as
  // db_cnt reaches DEBOUNCE_CYCLES-1 (requires DEBOUNCE_CYCLES >= 2).
  assign db_done = (db_inc == DB_LAST);
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      sync_ff    <= 2'b11;
      state      <= S_IDLE;
      db_cnt     <= '0;
      hd_cnt     <= '0;
      key_level  <= 1'b0;
      soft_reset <= 1'b0;
      hard_reset <= 1'b0;
    end else begin
      sync_ff    <= {sync_ff[0], key_n};
      soft_reset <= 1'b0;
      case (state)
        S_IDLE: begin
          if (key_s) begin
            state  <= S_PRESS_DB;
            db_cnt <= '0;
          end
        end
        S_PRESS_DB: begin
          if (!key_s) begin
            state <= S_IDLE;
          end else begin
            db_cnt <= db_inc;
            if (db_done) begin
              state     <= S_HELD;
              key_level <= 1'b1;
              hd_cnt    <= '0;
            end
          end
        end
        S_HELD: begin
          if (key_s) begin
            if (hd_cnt == LONG_LAST) begin
              state      <= S_LONG;
              hard_reset <= 1'b1;
            end else begin
              hd_cnt <= hd_inc;
            end
          end else begin
            state  <= S_REL_DB;
            db_cnt <= '0;
          end
        end
        S_REL_DB: begin
          // hd_cnt is left untouched so a release bounce resumes the hold count
          if (key_s) begin
            state <= S_HELD;
          end else begin
            db_cnt <= db_inc;
            if (db_done) begin
              state      <= S_IDLE;
              key_level  <= 1'b0;
              soft_reset <= 1'b1;
            end
          end
        end
        S_LONG: begin
          hard_reset <= 1'b1;
          if (!key_s) begin
            state  <= S_LREL_DB;
            db_cnt <= '0;
          end
        end
        S_LREL_DB: begin
          if (key_s) begin
            state <= S_LONG;
          end else begin
            db_cnt <= db_inc;
            if (db_done) begin
              state     <= S_STRETCH;
              key_level <= 1'b0;
              hd_cnt    <= '0;
            end
          end
        end
        S_STRETCH: begin
          if (hd_cnt == HOLD_LAST) begin
            state      <= S_IDLE;
            hard_reset <= 1'b0;
          end else begin
            hd_cnt <= hd_inc;
          end
        end
        default: begin
          state      <= S_IDLE;
          key_level  <= 1'b0;
          hard_reset <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_request_gen.sv
// Scoreboard bench for reset_request_gen: press durations map to expected event cycles
// by the latency rules; a monitor pops and compares each observed output edge.
module tb_reset_request_gen;

  localparam int D = 4;
  localparam int L = 20;
  localparam int H = 8;

  localparam int K_LR = 0;
  localparam int K_LF = 1;
  localparam int K_SOFT = 2;
  localparam int K_HR = 3;
  localparam int K_HF = 4;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clock = 1'b0;
  logic reset_in;
  logic key_n;
  logic key_level, soft_reset, hard_reset, busy;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  ev_t  sb[$];
  logic p_lvl = 1'b0;
  logic p_hard = 1'b0;

  reset_request_gen #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L),
    .HOLD_CYCLES(H),
    .CNT_W(8)
  ) dut (
    .clock(clock),
    .reset_in(reset_in),
    .key_n(key_n),
    .key_level(key_level),
    .soft_reset(soft_reset),
    .hard_reset(hard_reset),
    .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic push(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_ev(input int kind);
    ev_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d want nothing", kind, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        bad++;
        $display("FAIL event_order: got kind %0d at cycle %0d want kind %0d at cycle %0d",
                 kind, cyc, e.kind, e.cyc);
      end
    end
  endtask

  // monitor: every output edge must match the head of the scoreboard
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL missing_event: got nothing want kind %0d at cycle %0d (now %0d)",
               sb[0].kind, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if (key_level && !p_lvl)   check_ev(K_LR);
    if (!key_level && p_lvl)   check_ev(K_LF);
    if (soft_reset)            check_ev(K_SOFT);
    if (hard_reset && !p_hard) check_ev(K_HR);
    if (!hard_reset && p_hard) check_ev(K_HF);
    if (soft_reset && hard_reset) begin
      total++;
      bad++;
      $display("FAIL soft_hard_overlap: got both high want exclusive (cycle %0d)", cyc);
    end
    p_lvl  = key_level;
    p_hard = hard_reset;
  end

  // Clean press of p cycles starting from IDLE; expected events from the latency rules.
  task automatic do_press(input int p);
    int c;
    @(negedge clock);
    c = cyc;
    if (p >= D) push(K_LR, c + D + 2);
    if (p >= D + L) begin
      push(K_HR, c + D + 2 + L);
      push(K_LF, c + p + D + 2);
      push(K_HF, c + p + D + 2 + H);
    end else if (p >= D) begin
      push(K_LF, c + p + D + 2);
      push(K_SOFT, c + p + D + 2);
    end
    key_n = 1'b0;
    repeat (p) @(negedge clock);
    key_n = 1'b1;
  endtask

  task automatic idle_wait(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int c;
    int p;
    int bnd[4];
    reset_in = 1'b1;
    key_n    = 1'b1;

    // 1: reset held with key toggling
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      key_n = 1'($urandom);
      if (i % 5 == 4) chk("reset_outputs", {key_level, soft_reset, hard_reset, busy}, 0);
    end
    @(negedge clock);
    key_n    = 1'b1;
    reset_in = 1'b0;
    idle_wait(6);
    chk("post_reset_outputs", {key_level, soft_reset, hard_reset, busy}, 0);

    // 2: glitch of 3 cycles is rejected
    do_press(3);
    chk("glitch_busy_mid", busy, 1);
    idle_wait(D + 6);
    chk("glitch_busy_end", busy, 0);
    chk("glitch_level", key_level, 0);

    // 3: short press; 4: long press
    do_press(10);
    idle_wait(D + H + 10);
    do_press(40);
    idle_wait(D + H + 10);
    chk("after_long_idle", {key_level, hard_reset, busy}, 0);

    // 5: release bounce (low 10, high 2, low 2, then clean release)
    @(negedge clock);
    c = cyc;
    push(K_LR, c + D + 2);
    push(K_LF, c + 15 + 2 + D - 1);
    push(K_SOFT, c + 15 + 2 + D - 1);
    key_n = 1'b0;
    idle_wait(10);
    key_n = 1'b1;
    idle_wait(2);
    key_n = 1'b0;
    idle_wait(2);
    key_n = 1'b1;
    idle_wait(D + H + 10);

    // random presses across glitch / short / long regimes and their boundaries
    bnd[0] = D - 1;
    bnd[1] = D;
    bnd[2] = D + L - 1;
    bnd[3] = D + L;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0: p = $urandom_range(1, D - 1);
        1: p = $urandom_range(D, D + L - 1);
        2: p = $urandom_range(D + L, D + L + 15);
        default: p = bnd[$urandom_range(0, 3)];
      endcase
      do_press(p);
      idle_wait($urandom_range(D + H + 6, D + H + 15));
    end

    // 6: reset pulse during STRETCH drops hard_reset asynchronously
    do_press(30);
    void'(sb.pop_back());
    idle_wait(8);
    #2;
    push(K_HF, cyc + 1);
    reset_in = 1'b1;
    #1;
    chk("async_hard_drop", hard_reset, 0);
    chk("async_busy_drop", busy, 0);
    idle_wait(3);
    reset_in = 1'b0;
    idle_wait(6);
    chk("after_abort_outputs", {key_level, soft_reset, hard_reset, busy}, 0);

    idle_wait(40);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
